global_mem_responder: RTL and testbench
=======================================

GLOBAL_MEM_RESPONDER -- requirements
Module: global_mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning word-address width.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning number of stored words (≤ 2^ADDR_W).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  responder accepts request.
REQ-008 SHALL have port req_write  input  1  1 = write burst, 0 = read burst.
REQ-009 SHALL have port req_addr  input  ADDR_W  first word address.
REQ-010 SHALL have port req_len  input  3  burst beats minus one (1..8 beats).
REQ-011 SHALL have port req_wmask  input  DATA_W/8  byte-enable, applied to every beat of a write burst.
REQ-012 SHALL have port wdata_valid  input  1  write beat present.
REQ-013 SHALL have port wdata  input  DATA_W  write beat data.
REQ-014 SHALL have port wdata_ready  output  1  responder accepts write beat.
REQ-015 SHALL have port rdata_valid  output  1  read beat present.
REQ-016 SHALL have port rdata  output  DATA_W  read beat data.
REQ-017 SHALL have port rdata_last  output  1  marks final read beat.
REQ-018 SHALL have port rdata_ready  input  1  initiator accepts read beat.
REQ-019 SHALL have port wr_done  output  1  one-cycle pulse, write burst committed.
REQ-020 SHALL have port err  output  1  one-cycle pulse, request rejected.

Function
REQ-021 SHALL implement states IDLE, RD_FETCH, RD_SEND, WR_BEAT, WR_ACK, ERR.
REQ-022 SHALL assert req_ready only in IDLE; handshake = req_valid & req_ready; on handshake latch write, addr, len, wmask and clear beat counter.
REQ-023 SHALL, on handshake with req_addr + req_len ≥ DEPTH, go to ERR (no wrap-around, no memory access); ERR drives err=1 for exactly one cycle, then IDLE.
REQ-024 SHALL, on a valid read handshake, go to RD_FETCH; RD_FETCH performs one synchronous array read of mem[addr], then goes to RD_SEND.
REQ-025 SHALL, in RD_SEND, drive rdata_valid=1 with rdata and rdata_last (beat counter == len) held stable until rdata_ready=1.
REQ-026 SHALL, on a read-beat handshake, go to IDLE if last; otherwise increment addr and beat counter and go to RD_FETCH. Latency: request handshake at cycle N gives first rdata_valid at N+2; sustained throughput is one beat per 2 cycles.
REQ-027 SHALL, on a valid write handshake, go to WR_BEAT; WR_BEAT drives wdata_ready=1.
REQ-028 SHALL, on wdata_valid & wdata_ready, write each byte of wdata whose mask bit is set to mem[addr] (unmasked bytes unchanged); go to WR_ACK if last, else increment addr and beat counter.
REQ-029 SHALL, in WR_ACK, drive wr_done=1 for one cycle, then IDLE; the next request may be accepted the following cycle.
REQ-030 SHALL make a read issued after wr_done return the newly written data (no stale read).
REQ-031 SHALL hold rdata_valid, wdata_ready, wr_done and err at 0 outside their stated states; wdata presented outside WR_BEAT is ignored.
REQ-032 SHALL treat req_wmask = 0 as a legal write that changes no bytes but still completes with wr_done.

Reset
REQ-033 SHALL, on reset, go to IDLE and clear addr, beat counter, rdata_valid, rdata_last, wr_done, err and wdata_ready to 0; rdata resets to 0.
REQ-034 SHALL, on reset mid-burst, abort without wr_done or further beats; beats already written stay committed. Memory contents are not cleared by reset.
REQ-035 SHALL give reset priority over any simultaneous handshake.

Verification
REQ-036 Write addr 0x010, len 3, mask 0xF, data 0xA0..0xA3 -> wr_done 1 cycle after 4th beat; read same -> 4 beats 0xA0..0xA3, rdata_last only on 0xA3, first beat at N+2.
REQ-037 Write 0x12345678 at addr 5, then write 0xFFFFFFFF mask 0x2 -> read returns 0x1234FF78.
REQ-038 Read len 7 with rdata_ready low 5 cycles on beat 2 -> rdata and rdata_last stable throughout; no beat lost or duplicated.
REQ-039 Request addr 0x3FE, len 3 (DEPTH 1024) -> err pulse 1 cycle; no wdata_ready, no rdata_valid; memory at 0x3FE/0x3FF unchanged.
REQ-040 Reset asserted after 2 of 4 write beats -> IDLE next cycle, no wr_done, req_ready=1; read shows beats 0-1 written, beats 2-3 unchanged.

Source files
------------

// File: rtl/global_mem_responder.sv
// Burst memory responder: single-port word array serving 1..8 beat read/write bursts
// with per-byte write masks, bounds checking and a ready/valid beat interface.
module global_mem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [2:0]            req_len,
    input  logic [DATA_W/8-1:0]   req_wmask,
    input  logic                  wdata_valid,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  wdata_ready,
    output logic                  rdata_valid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rdata_last,
    input  logic                  rdata_ready,
    output logic                  wr_done,
    output logic                  err
);

    localparam int MASK_W = DATA_W / 8;
    localparam int SUM_W  = ADDR_W + 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_SEND,
        WR_BEAT,
        WR_ACK,
        ERR
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        len_q;
    logic [2:0]        beat_q;
    logic [MASK_W-1:0] wmask_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rdata_last_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [SUM_W-1:0]  end_addr;
    logic              out_of_range;
    logic              req_fire;
    logic              rd_fire;
    logic              wr_fire;
    logic              beat_last;

    // The last beat's address must still be inside the array; bursts never wrap.
    assign end_addr     = SUM_W'(req_addr) + SUM_W'(req_len);
    assign out_of_range = (end_addr >= SUM_W'(DEPTH));

    assign req_fire  = (state == IDLE)    && req_valid;
    assign rd_fire   = (state == RD_SEND) && rdata_ready;
    assign wr_fire   = (state == WR_BEAT) && wdata_valid;
    assign beat_last = (beat_q == len_q);

    assign rdata      = rdata_q;
    assign rdata_last = rdata_last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        rdata_valid = 1'b0;
        wr_done     = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (out_of_range) begin
                        state_next = ERR;
                    end else if (req_write) begin
                        state_next = WR_BEAT;
                    end else begin
                        state_next = RD_FETCH;
                    end
                end
            end
            RD_FETCH: begin
                state_next = RD_SEND;
            end
            RD_SEND: begin
                rdata_valid = 1'b1;
                if (rdata_ready) begin
                    state_next = beat_last ? IDLE : RD_FETCH;
                end
            end
            WR_BEAT: begin
                wdata_ready = 1'b1;
                if (wdata_valid && beat_last) begin
                    state_next = WR_ACK;
                end
            end
            WR_ACK: begin
                wr_done    = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                err        = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, beat stepping and the registered read port; rdata only
    // changes in RD_FETCH so it stays stable while a beat is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            wmask_q      <= '0;
            rdata_q      <= '0;
            rdata_last_q <= 1'b0;
        end else begin
            if (req_fire) begin
                addr_q  <= req_addr;
                len_q   <= req_len;
                wmask_q <= req_wmask;
                beat_q  <= '0;
            end
            if ((rd_fire || wr_fire) && !beat_last) begin
                addr_q <= addr_q + 1'b1;
                beat_q <= beat_q + 1'b1;
            end
            if (state == RD_FETCH) begin
                rdata_q      <= mem[addr_q];
                rdata_last_q <= beat_last;
            end
        end
    end

    // Contents survive reset; reset only suppresses a write beat landing on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && wr_fire) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (wmask_q[b]) begin
                    mem[addr_q][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_global_mem_responder.sv
// Self-checking bench for global_mem_responder: directed corner cases, a request
// table and randomized bursts checked against a word-array reference model.
module tb_global_mem_responder;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_len;
    logic [3:0]        req_wmask;
    logic              wdata_valid;
    logic [31:0]       wdata;
    logic              wdata_ready;
    logic              rdata_valid;
    logic [31:0]       rdata;
    logic              rdata_last;
    logic              rdata_ready;
    logic              wr_done;
    logic              err;

    global_mem_responder #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wmask  (req_wmask),
        .wdata_valid(wdata_valid),
        .wdata      (wdata),
        .wdata_ready(wdata_ready),
        .rdata_valid(rdata_valid),
        .rdata      (rdata),
        .rdata_last (rdata_last),
        .rdata_ready(rdata_ready),
        .wr_done    (wr_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vectors;
    int          n_miscompares;
    logic [31:0] model [DEPTH];

    typedef struct {
        logic       wr;
        logic [9:0] addr;
        logic [2:0] len;
        logic [3:0] mask;
        logic       exp_err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present a request and complete its handshake; returns just after the accepting edge.
    task automatic applyStimulus(input logic wr, input logic [9:0] addr, input logic [2:0] len,
                                 input logic [3:0] mask);
        int budget;
        budget    = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_len   = len;
        req_wmask = mask;
        while (!req_ready && budget < 20) begin
            tick();
            budget++;
        end
        checkOutput("req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 10'($urandom);
        req_len   = 3'($urandom);
        req_wmask = 4'($urandom);
    endtask

    task automatic model_write(input int addr, input logic [3:0] mask, input logic [31:0] data);
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) model[addr][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    task automatic write_burst(input logic [9:0] addr, input logic [2:0] len, input logic [3:0] mask,
                               input logic [31:0] beats [8], input bit gaps);
        applyStimulus(1'b1, addr, len, mask);
        checkOutput("err_on_write", err, 0);
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wdata_valid = 1'b0;
                wdata       = $urandom;
                checkOutput("wdata_ready_gap", wdata_ready, 1);
                tick();
            end
            wdata_valid = 1'b1;
            wdata       = beats[i];
            checkOutput("wdata_ready", wdata_ready, 1);
            checkOutput("wr_done_early", wr_done, 0);
            tick();
            model_write(int'(addr) + i, mask, beats[i]);
        end
        wdata_valid = 1'b0;
        wdata       = $urandom;
        checkOutput("wr_done", wr_done, 1);
        checkOutput("wdata_ready_ack", wdata_ready, 0);
        tick();
        checkOutput("wr_done_pulse", wr_done, 0);
        checkOutput("req_ready_after_wr", req_ready, 1);
    endtask

    task automatic read_burst(input logic [9:0] addr, input logic [2:0] len, input int stall_beat,
                              input int stall_cycles, input bit rnd_stall);
        logic [31:0] exp_data;
        int          n;
        applyStimulus(1'b0, addr, len, 4'h0);
        checkOutput("err_on_read", err, 0);
        checkOutput("rd_fetch_valid", rdata_valid, 0);
        for (int i = 0; i <= int'(len); i++) begin
            tick();
            exp_data = model[int'(addr) + i];
            checkOutput("rdata_valid", rdata_valid, 1);
            checkOutput("rdata", rdata, exp_data);
            checkOutput("rdata_last", rdata_last, (i == int'(len)));
            n = (i == stall_beat) ? stall_cycles : (rnd_stall ? $urandom_range(0, 2) : 0);
            rdata_ready = 1'b0;
            repeat (n) begin
                tick();
                checkOutput("stall_valid", rdata_valid, 1);
                checkOutput("stall_rdata", rdata, exp_data);
                checkOutput("stall_last", rdata_last, (i == int'(len)));
            end
            rdata_ready = 1'b1;
            tick();
            rdata_ready = 1'b0;
            checkOutput("rdata_gap", rdata_valid, 0);
        end
        checkOutput("req_ready_after_rd", req_ready, 1);
    endtask

    task automatic err_request(input logic wr, input logic [9:0] addr, input logic [2:0] len);
        applyStimulus(wr, addr, len, 4'hF);
        wdata_valid = 1'b1;
        wdata       = $urandom;
        checkOutput("err_pulse", err, 1);
        checkOutput("err_wdata_ready", wdata_ready, 0);
        checkOutput("err_rdata_valid", rdata_valid, 0);
        tick();
        wdata_valid = 1'b0;
        checkOutput("err_cleared", err, 0);
        checkOutput("req_ready_after_err", req_ready, 1);
        checkOutput("err_no_wdata_ready", wdata_ready, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d [8];
        vec_t        table_v [8];
        logic [9:0]  a;
        logic [2:0]  l;

        n_vectors     = 0;
        n_miscompares = 0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_len     = '0;
        req_wmask   = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        rdata_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_rdata_valid", rdata_valid, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_rdata_last", rdata_last, 0);
        checkOutput("rst_wr_done", wr_done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_wdata_ready", wdata_ready, 0);

        $display("[TB] prefill memory");
        for (int base = 0; base < DEPTH; base += 8) begin
            for (int k = 0; k < 8; k++) d[k] = $urandom;
            write_burst(10'(base), 3'd7, 4'hF, d, 1'b0);
        end

        $display("[TB] burst of four written then read back");
        for (int k = 0; k < 8; k++) d[k] = 32'hA0 + k;
        write_burst(10'h010, 3'd3, 4'hF, d, 1'b0);
        read_burst(10'h010, 3'd3, -1, 0, 1'b0);

        $display("[TB] byte-masked overwrite");
        d[0] = 32'h12345678;
        write_burst(10'd5, 3'd0, 4'hF, d, 1'b0);
        d[0] = 32'hFFFFFFFF;
        write_burst(10'd5, 3'd0, 4'h2, d, 1'b0);
        read_burst(10'd5, 3'd0, -1, 0, 1'b0);
        checkOutput("masked_word", rdata, 32'h1234FF78);

        $display("[TB] eight beat read with stalled third beat");
        read_burst(10'h100, 3'd7, 2, 5, 1'b0);

        $display("[TB] out of range request");
        err_request(1'b1, 10'h3FE, 3'd3);
        read_burst(10'h3FE, 3'd1, -1, 0, 1'b0);

        $display("[TB] reset in the middle of a write burst");
        applyStimulus(1'b1, 10'h200, 3'd3, 4'hF);
        for (int i = 0; i < 2; i++) begin
            wdata_valid = 1'b1;
            wdata       = 32'hC0DE_0000 + i;
            tick();
            model_write(10'h200 + i, 4'hF, 32'hC0DE_0000 + i);
        end
        wdata_valid = 1'b1;
        wdata       = 32'hDEAD_BEEF;
        reset       = 1'b1;
        tick();
        reset       = 1'b0;
        wdata_valid = 1'b0;
        checkOutput("abort_req_ready", req_ready, 1);
        checkOutput("abort_wr_done", wr_done, 0);
        checkOutput("abort_wdata_ready", wdata_ready, 0);
        tick();
        checkOutput("abort_wr_done_later", wr_done, 0);
        read_burst(10'h200, 3'd3, -1, 0, 1'b0);

        $display("[TB] zero mask write and stray write data");
        for (int k = 0; k < 8; k++) d[k] = $urandom;
        write_burst(10'h300, 3'd2, 4'h0, d, 1'b0);
        repeat (3) begin
            wdata_valid = 1'b1;
            wdata       = $urandom;
            checkOutput("idle_wdata_ready", wdata_ready, 0);
            tick();
        end
        wdata_valid = 1'b0;
        read_burst(10'h300, 3'd2, -1, 0, 1'b0);

        $display("[TB] request table");
        table_v[0] = '{wr: 1'b0, addr: 10'h3FF, len: 3'd0, mask: 4'h0, exp_err: 1'b0};
        table_v[1] = '{wr: 1'b1, addr: 10'h3FF, len: 3'd1, mask: 4'hF, exp_err: 1'b1};
        table_v[2] = '{wr: 1'b1, addr: 10'h3F8, len: 3'd7, mask: 4'h5, exp_err: 1'b0};
        table_v[3] = '{wr: 1'b0, addr: 10'h3F9, len: 3'd7, mask: 4'h0, exp_err: 1'b1};
        table_v[4] = '{wr: 1'b0, addr: 10'h3F8, len: 3'd7, mask: 4'h0, exp_err: 1'b0};
        table_v[5] = '{wr: 1'b1, addr: 10'h000, len: 3'd7, mask: 4'hA, exp_err: 1'b0};
        table_v[6] = '{wr: 1'b0, addr: 10'h000, len: 3'd7, mask: 4'h0, exp_err: 1'b0};
        table_v[7] = '{wr: 1'b0, addr: 10'h3FC, len: 3'd4, mask: 4'h0, exp_err: 1'b1};
        for (int v = 0; v < 8; v++) begin
            if (table_v[v].exp_err) begin
                err_request(table_v[v].wr, table_v[v].addr, table_v[v].len);
            end else if (table_v[v].wr) begin
                for (int k = 0; k < 8; k++) d[k] = $urandom;
                write_burst(table_v[v].addr, table_v[v].len, table_v[v].mask, d, 1'b0);
            end else begin
                read_burst(table_v[v].addr, table_v[v].len, -1, 0, 1'b0);
            end
        end

        $display("[TB] randomized bursts");
        for (int t = 0; t < 200; t++) begin
            a = 10'($urandom);
            if ($urandom_range(0, 7) == 0) a = 10'($urandom_range(DEPTH - 8, DEPTH - 1));
            l = 3'($urandom);
            if (int'(a) + int'(l) >= DEPTH) begin
                err_request(1'($urandom), a, l);
            end else if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 8; k++) d[k] = $urandom;
                write_burst(a, l, 4'($urandom), d, 1'b1);
            end else begin
                read_burst(a, l, -1, 0, 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
